// File: rtl/beep_driver_pkg.sv
// Shared types and constants for the buzzer pattern driver.
package beep_driver_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StGap  = 2'd2
    } state_e;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_SHORT1 = 2'd0;
    localparam mode_t MODE_LONG1  = 2'd1;
    localparam mode_t MODE_SHORT3 = 2'd2;
    localparam mode_t MODE_LONG2  = 2'd3;

    // Defaults for a 50 MHz clock.
    localparam logic [31:0] DEF_CNT_1MS_MAX = 32'd49_999;
    localparam logic [15:0] DEF_SHORT_MS    = 16'd100;
    localparam logic [15:0] DEF_LONG_MS     = 16'd500;
    localparam logic [15:0] DEF_GAP_MS      = 16'd100;

    // Number of beeps in the pattern selected by a mode.
    function automatic logic [1:0] beep_count(mode_t m);
        case (m)
            MODE_SHORT1: return 2'd1;
            MODE_LONG1:  return 2'd1;
            MODE_SHORT3: return 2'd3;
            default:     return 2'd2;
        endcase
    endfunction

    // True when the mode uses long beeps.
    function automatic logic is_long(mode_t m);
        return (m == MODE_LONG1) || (m == MODE_LONG2);
    endfunction

endpackage

// File: rtl/beep_driver_if.sv
// Request/status bundle between the lock controller and the buzzer driver.
interface beep_driver_if;
    import beep_driver_pkg::*;

    logic  req;
    mode_t mode;
    logic  buzzer;
    logic  busy;
    logic  done;

    modport master (output req, output mode, input buzzer, input busy, input done);
    modport slave  (input req, input mode, output buzzer, output busy, output done);

endinterface

// File: rtl/beep_driver_ms_tick_gen.sv
// 1 ms prescaler with a clearable millisecond counter.
module ms_tick_gen
    import beep_driver_pkg::*;
#(
    parameter logic [31:0] CNT_MAX = DEF_CNT_1MS_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    output logic        tick,
    output logic [15:0] ms_cnt
);

    logic [31:0] pre_q;
    logic [15:0] ms_q;

    // High on the last prescaler cycle of each millisecond.
    assign tick   = (pre_q == CNT_MAX);
    assign ms_cnt = ms_q;

    // Prescaler wraps at CNT_MAX and bumps the ms counter; clr restarts both.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            pre_q <= 32'd0;
            ms_q  <= 16'd0;
        end else if (tick) begin
            pre_q <= 32'd0;
            ms_q  <= ms_q + 16'd1;
        end else begin
            pre_q <= pre_q + 32'd1;
        end
    end

endmodule

// File: rtl/beep_driver.sv
// Turns a one-cycle request into a timed buzzer pattern of short/long beeps.
module beep_driver
    import beep_driver_pkg::*;
#(
    parameter logic [31:0] CNT_1MS_MAX = DEF_CNT_1MS_MAX,
    parameter logic [15:0] SHORT_MS    = DEF_SHORT_MS,
    parameter logic [15:0] LONG_MS     = DEF_LONG_MS,
    parameter logic [15:0] GAP_MS      = DEF_GAP_MS
) (
    input  logic          clk,
    input  logic          rst_n,
    beep_driver_if.slave  bus
);

    state_e      state_q, state_d;
    mode_t       mode_q, mode_d;
    logic [1:0]  rem_q, rem_d;
    logic        done_d;
    logic        buzzer_q, busy_q, done_q;
    logic        tick, clr, phase_end;
    logic [15:0] ms_cnt, phase_ms;

    ms_tick_gen #(
        .CNT_MAX (CNT_1MS_MAX)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .tick   (tick),
        .ms_cnt (ms_cnt)
    );

    // Phase ends on the tick that makes the ms count reach the phase length,
    // so each phase lasts exactly N ms worth of clocks.
    assign phase_ms  = (state_q == StGap) ? GAP_MS : (is_long(mode_q) ? LONG_MS : SHORT_MS);
    assign phase_end = tick && ((ms_cnt + 16'd1) == phase_ms);
    assign clr       = (state_d != state_q);

    // Next-state logic: accept requests only in idle, sequence beeps and gaps.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req) begin
                    mode_d  = bus.mode;
                    rem_d   = beep_count(bus.mode);
                    state_d = StOn;
                end
            end
            StOn: begin
                if (phase_end) begin
                    rem_d = rem_q - 2'd1;
                    if (rem_q == 2'd1) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StGap: begin
                if (phase_end) begin
                    state_d = StOn;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; outputs track the next state so they
    // change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mode_q   <= MODE_SHORT1;
            rem_q    <= 2'd0;
            buzzer_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            rem_q    <= rem_d;
            buzzer_q <= (state_d == StOn);
            busy_q   <= (state_d != StIdle);
            done_q   <= done_d;
        end
    end

    assign bus.buzzer = buzzer_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

    // A zero-length phase would never end.
    zero_ms_param_a: assert property (@(posedge clk)
        (SHORT_MS != 16'd0) && (LONG_MS != 16'd0) && (GAP_MS != 16'd0));

endmodule
